sram_1r1w_param: RTL and testbench
==================================

# sram_1r1w_param

Parametrised single-clock, one-read/one-write SRAM macro model for the accelerator's feature-map and weight buffers. It generalises the fixed 128x512 dual-port model with configurable width and depth, per-byte write masking, and read-during-write forwarding. It also adds a hardware clear sweep and a read-valid handshake. It sits between the buffer controllers and the compute array, and is a drop-in for all on-chip buffer instances.

## Interface
- DATA_WIDTH, 128, word width in bits; must be a multiple of 8
- DEPTH, 512, number of words; need not be a power of two
- ADDR_WIDTH, $clog2(DEPTH), address width (derived, not overridden)
- MASK_WIDTH, DATA_WIDTH/8, byte-enable width (derived)

- clk  in  1  clock, all logic on rising edge
- arst_n  in  1  asynchronous active-low reset
- clr_req  in  1  single-cycle pulse: start zero-fill sweep of whole array
- busy  out  1  high while sweep runs
- wr_en  in  1  write request
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_mask  in  MASK_WIDTH  byte enables, bit i covers wr_data[8i+7:8i]
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  read data
- rd_valid  out  1  rd_data holds the result of a read issued LAT cycles earlier

## Operation
- Write: on a rising edge with wr_en=1, busy=0 and wr_addr<DEPTH, the enabled bytes of mem[wr_addr] are updated. Disabled bytes are untouched.
- Read: on a rising edge with rd_en=1 and busy=0, the word is fetched. rd_addr>=DEPTH returns all zeros.
- Read-during-write to the same address in the same cycle: returns the merged new word, i.e. masked bytes from wr_data and the remaining bytes from the old contents. No warning, no X.
- rd_data holds its last value when no read completes. rd_valid is a one-cycle pulse per completed read.
- Clear FSM states:
  - IDLE: clr_req=1 -> CLEAR, ptr<=0.
  - CLEAR: writes zero to mem[ptr] and increments ptr each cycle; at ptr==DEPTH-1 -> IDLE.
  - busy=1 exactly in CLEAR, for DEPTH cycles.
- During CLEAR, wr_en and rd_en are ignored (dropped, not queued) and rd_valid stays 0. clr_req in CLEAR is ignored.
- Memory array is not reset. Contents after power-up are X until written or cleared.

## Timing
- Base read latency LAT=1: rd_data/rd_valid update on the edge after rd_en is sampled.
- Write visible to a read issued in the same cycle (forwarding) and in any later cycle.
- busy rises on the edge sampling clr_req. It falls DEPTH cycles later, and a read issued on that cycle is accepted.
- Reset values: rd_data=0, rd_valid=0, busy=0, FSM=IDLE, ptr=0.
- Reset mid-sweep: FSM returns to IDLE immediately and array contents are partially cleared (unspecified). Any read in flight is discarded and rd_valid=0.

## Configuration
- SRAM_OUT_REG_EN defined: an extra output pipeline register is inserted, giving LAT=2.
  - rd_valid and rd_data are delayed together.
  - The output register resets to 0.
  - A read issued on the last CLEAR cycle is still dropped.
- SRAM_OUT_REG_EN undefined: LAT=1 as above.

## Structure
- Package sram_pkg:
  - clr_state_t enum (CLR_IDLE, CLR_SWEEP)
  - default constants SRAM_DEF_WIDTH=128, SRAM_DEF_DEPTH=512
  - function byte_merge(old, new, mask)
- Sub-module sram_clear_fsm: owns state, ptr and busy, and outputs the sweep write port (en, addr). The top muxes the sweep port over the user write port.

## Test plan
- Write 0xA5..A5 to addr 3 with mask all-ones, read addr 3 next cycle -> rd_data=0xA5..A5, rd_valid=1 one cycle after rd_en (two with SRAM_OUT_REG_EN).
- Write 0xFF..FF to addr 7, then write 0x00..00 with mask 0x0001 -> read returns 0xFF..FF00.
- Same-cycle write 0x1234 (mask 0x0003) and read to addr 9 holding 0xFF..FF -> rd_data=0xFF..FF1234.
- clr_req pulse with DEPTH=512 -> busy high exactly 512 cycles; reads/writes during sweep are ignored; afterwards a read of any address returns 0.
- Assert arst_n low at sweep cycle 100 -> busy=0, rd_valid=0, rd_data=0 immediately; a fresh clr_req afterwards completes normally.
- DEPTH=300: write to addr 310 -> no change; read addr 310 -> rd_data=0, rd_valid=1.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types, defaults and byte-merge helper for the
// parametrised 1R1W SRAM model.
package sram_pkg;

  localparam int SRAM_DEF_WIDTH = 128;
  localparam int SRAM_DEF_DEPTH = 512;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_t;

  // One byte lane of a masked write: new byte if enabled, else old.
  function automatic logic [7:0] byte_merge(
    input logic [7:0] old_byte,
    input logic [7:0] new_byte,
    input logic       mask
  );
    return mask ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// Zero-fill sweep controller: walks ptr over the whole array
// and presents a write port that overrides user writes.
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter int DEPTH      = SRAM_DEF_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  sweep_en,
  output logic [ADDR_WIDTH-1:0] sweep_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  clr_state_t            state;
  logic [ADDR_WIDTH-1:0] ptr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= CLR_IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      unique case (state)
        CLR_IDLE: begin
          if (clr_req) begin
            state <= CLR_SWEEP;
            ptr   <= '0;
            busy  <= 1'b1;
          end
        end
        CLR_SWEEP: begin
          if (ptr == LAST) begin
            state <= CLR_IDLE;
            busy  <= 1'b0;
          end else begin
            ptr <= ptr + ADDR_WIDTH'(1);
          end
        end
      endcase
    end
  end

  assign sweep_en   = busy;
  assign sweep_addr = ptr;

endmodule

// File: rtl/sram_1r1w_param.sv
// Parametrised 1R1W SRAM with byte masks, same-cycle forwarding
// and clear sweep. SRAM_OUT_REG_EN adds an output register (LAT=2).
module sram_1r1w_param
  import sram_pkg::*;
#(
  parameter  int DATA_WIDTH = SRAM_DEF_WIDTH,
  parameter  int DEPTH      = SRAM_DEF_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH),
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  clr_req,
  output logic                  busy,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [MASK_WIDTH-1:0] wr_mask,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  sweep_en;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  rd_hit;
  logic [DATA_WIDTH-1:0] old_word;
  logic [DATA_WIDTH-1:0] wr_word;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_next;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  vld_q;

  sram_clear_fsm #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clr (
    .clk        (clk),
    .arst_n     (arst_n),
    .clr_req    (clr_req),
    .busy       (busy),
    .sweep_en   (sweep_en),
    .sweep_addr (sweep_addr)
  );

  // One merged word serves both the array write and the forward path.
  always_comb begin
    wr_fire  = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
    rd_fire  = rd_en && !busy;
    rd_hit   = {1'b0, rd_addr} < DEPTH_W;
    old_word = wr_fire ? mem[wr_addr] : '0;
    wr_word  = '0;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      wr_word[8*i +: 8] = byte_merge(
        old_word[8*i +: 8], wr_data[8*i +: 8], wr_mask[i]);
    end
    rd_word = rd_hit ? mem[rd_addr] : '0;
    rd_next = (wr_fire && (wr_addr == rd_addr)) ? wr_word : rd_word;
  end

  always_ff @(posedge clk) begin
    if (sweep_en) begin
      mem[sweep_addr] <= '0;
    end else if (wr_fire) begin
      mem[wr_addr] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      vld_q <= rd_fire;
      if (rd_fire) begin
        rd_q <= rd_next;
      end
    end
  end

`ifdef SRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rd_q2;
  logic                  vld_q2;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rd_q2  <= '0;
      vld_q2 <= 1'b0;
    end else begin
      vld_q2 <= vld_q;
      if (vld_q) begin
        rd_q2 <= rd_q;
      end
    end
  end

  assign rd_data  = rd_q2;
  assign rd_valid = vld_q2;
`else
  assign rd_data  = rd_q;
  assign rd_valid = vld_q;
`endif

endmodule

// File: tb/tb_sram_1r1w_param.sv
// Scoreboard bench for sram_1r1w_param: a 128x512 instance and
// a 32x300 instance for the out-of-range address cases.
module tb_sram_1r1w_param;

`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         a_clr_req, a_busy, a_wr_en, a_rd_en, a_rd_valid;
  logic [8:0]   a_wr_addr, a_rd_addr;
  logic [127:0] a_wr_data, a_rd_data;
  logic [15:0]  a_wr_mask;

  logic         b_clr_req, b_busy, b_wr_en, b_rd_en, b_rd_valid;
  logic [8:0]   b_wr_addr, b_rd_addr;
  logic [31:0]  b_wr_data, b_rd_data;
  logic [3:0]   b_wr_mask;

  sram_1r1w_param #(.DATA_WIDTH(128), .DEPTH(512)) dut_a (
    .clk(clk), .arst_n(arst_n), .clr_req(a_clr_req), .busy(a_busy),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .wr_mask(a_wr_mask), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid)
  );

  sram_1r1w_param #(.DATA_WIDTH(32), .DEPTH(300)) dut_b (
    .clk(clk), .arst_n(arst_n), .clr_req(b_clr_req), .busy(b_busy),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .wr_mask(b_wr_mask), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  typedef struct {
    logic [127:0] data;
    int           due;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   n_tests = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per rd_valid pulse.
  always @(negedge clk) begin
    if (a_busy) busy_cnt++;
    if (a_rd_valid) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_spurious_valid: got rd_valid=1 want 0");
      end else begin
        ea = qa.pop_front();
        check("a_rd_data", a_rd_data, ea.data);
        check("a_rd_lat", 128'(cyc), 128'(ea.due));
      end
    end else if (qa.size() > 0 && qa[0].due <= cyc) begin
      ea = qa.pop_front();
      check("a_rd_missing", 128'(a_rd_valid), 128'(1));
    end
  end

  always @(negedge clk) begin
    if (b_rd_valid) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_spurious_valid: got rd_valid=1 want 0");
      end else begin
        eb = qb.pop_front();
        check("b_rd_data", 128'(b_rd_data), eb.data);
        check("b_rd_lat", 128'(cyc), 128'(eb.due));
      end
    end else if (qb.size() > 0 && qb[0].due <= cyc) begin
      eb = qb.pop_front();
      check("b_rd_missing", 128'(b_rd_valid), 128'(1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_idle();
    a_wr_en = 1'b0;
    a_rd_en = 1'b0;
    a_clr_req = 1'b0;
  endtask

  task automatic a_write(input logic [8:0] addr,
                         input logic [127:0] data,
                         input logic [15:0] mask);
    a_wr_en = 1'b1;
    a_wr_addr = addr;
    a_wr_data = data;
    a_wr_mask = mask;
  endtask

  task automatic a_read(input logic [8:0] addr,
                        input logic [127:0] exp, input bit push);
    a_rd_en = 1'b1;
    a_rd_addr = addr;
    if (push) qa.push_back('{exp, cyc + LAT});
  endtask

  task automatic a_wait_sweep(input string name);
    for (int i = 0; i < 600 && a_busy; i++) step();
    check(name, 128'(busy_cnt), 128'(512));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    a_idle();
    a_wr_addr = '0; a_wr_data = '0; a_wr_mask = '0; a_rd_addr = '0;
    b_clr_req = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
    b_wr_addr = '0; b_wr_data = '0; b_wr_mask = '0; b_rd_addr = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_data", a_rd_data, '0);
    check("rst_rd_valid", 128'(a_rd_valid), '0);
    check("rst_busy", 128'(a_busy), '0);
    arst_n = 1'b1;
    step();

    a_write(3, {16{8'hA5}}, 16'hFFFF); step(); a_idle();
    a_read(3, {16{8'hA5}}, 1); step(); a_idle();

    a_write(7, {16{8'hFF}}, 16'hFFFF); step();
    a_write(7, '0, 16'h0001); step(); a_idle();
    a_read(7, {{15{8'hFF}}, 8'h00}, 1); step(); a_idle();

    a_write(9, {16{8'hFF}}, 16'hFFFF); step();
    a_write(9, 128'h1234, 16'h0003);
    a_read(9, {{14{8'hFF}}, 16'h1234}, 1); step(); a_idle();

    a_write(20, {16{8'h11}}, 16'hFFFF); step();
    a_write(20, {16{8'hEE}}, 16'h0F00); step(); a_idle();
    a_read(20, {{4{8'h11}}, {4{8'hEE}}, {8{8'h11}}}, 1); step();
    a_idle(); step(); step();

    busy_cnt = 0;
    a_clr_req = 1'b1; step(); a_idle();
    check("busy_rise", 128'(a_busy), 128'(1));
    repeat (8) step();
    a_write(5, {16{8'hDE}}, 16'hFFFF);
    a_read(5, '0, 0);
    a_clr_req = 1'b1;
    step(); a_idle();
    a_wait_sweep("busy_cycles");
    a_read(3, '0, 1); step();
    a_read(5, '0, 1); step();
    a_read(7, '0, 1); step();
    a_read(9, '0, 1); step();
    a_read(511, '0, 1); step(); a_idle();

    a_write(400, {16{8'h55}}, 16'hFFFF); step(); a_idle();
    a_read(400, {16{8'h55}}, 1); step(); a_idle();
    repeat (3) step();
    a_clr_req = 1'b1; step(); a_idle();
    repeat (99) step();
    arst_n = 1'b0;
    #1;
    check("midrst_busy", 128'(a_busy), '0);
    check("midrst_rd_valid", 128'(a_rd_valid), '0);
    check("midrst_rd_data", a_rd_data, '0);
    step();
    arst_n = 1'b1;
    step();
    busy_cnt = 0;
    a_clr_req = 1'b1; step(); a_idle();
    a_wait_sweep("busy_cycles_2");
    a_read(400, '0, 1); step(); a_idle();
    repeat (3) step();

    b_wr_en = 1'b1; b_wr_addr = 299;
    b_wr_data = 32'h11223344; b_wr_mask = 4'hF; step();
    b_wr_addr = 310; b_wr_data = 32'hCAFEBABE; step();
    b_wr_en = 1'b0;
    b_rd_en = 1'b1; b_rd_addr = 310;
    qb.push_back('{128'(0), cyc + LAT}); step();
    b_rd_addr = 299;
    qb.push_back('{128'(32'h11223344), cyc + LAT}); step();
    b_rd_en = 1'b0;
    repeat (4) step();

    check("qa_drained", 128'(qa.size()), '0);
    check("qb_drained", 128'(qb.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
